ddr3_mcb_dat_sched: RTL and testbench
=====================================

Name: ddr3_mcb_dat_sched

Overview:
Parametrised, runtime-configurable data-path scheduler for the DDR3 MCB.
- Receives read and write command strobes from the command FSM, each flagged BL8 or BC4.
- Generates the data-path enables (d_dp_ie, d_dp_oe, d_wr_ld), the user-side write-data request and the read-data valid.
- Unlike the single-burst data control, it tracks up to 2^LAT_W-1 cycles of in-flight commands, supports seamless back-to-back bursts, runtime CL/CWL and burst chop, and reports timing collisions.
- Sits between the MCB command FSM and the DQ/DQS datapath.

Parameters:
LAT_W, 5, width of cfg_cl/cfg_cwl; maximum latency 2^LAT_W-1 cycles.
BL_CYC, 4, controller clocks per BL8 burst (BC4 = BL_CYC/2); must be an even power of two, >=2.
WREQ_LEAD, 2, cycles by which ddr3_mcb_wdat_req leads d_dp_oe.
RD_PIPE, 1, cycles from d_dp_ie to ddr3_mcb_rdat_vld (>=1).

Ports:
ddr3_mcb_clk  in  1  controller clock
ddr3_mcb_rst_n  in  1  asynchronous active-low reset
c_rd  in  1  read command issued this cycle
c_wr  in  1  write command issued this cycle
c_bc4  in  1  burst chop, qualifies c_rd/c_wr
cfg_cl  in  LAT_W  read latency, cycles from c_rd to first d_dp_ie
cfg_cwl  in  LAT_W  write latency, cycles from c_wr to first d_dp_oe
err_clr  in  1  clears d_err
d_dp_ie  out  1  read capture enable
d_dp_oe  out  1  write DQ/DQS output enable
d_wr_ld  out  1  load write output register, one cycle before each oe beat
ddr3_mcb_wdat_req  out  1  request one write beat from user side
ddr3_mcb_rdat_vld  out  1  read data valid to user side
d_beat  out  log2(BL_CYC)  beat index of the current ie/oe beat (ie has priority)
d_busy  out  1  any command in flight or burst active
d_err  out  1  sticky collision flag

Behaviour:
- Reset: all outputs 0, token pipeline and counters cleared. Assertion mid-operation aborts immediately; no beat is produced after release for commands issued before reset.

Timing (c_rd or c_wr at cycle T, n = BL_CYC, or BL_CYC/2 when c_bc4=1):
- Read: d_dp_ie high T+cfg_cl .. T+cfg_cl+n-1; ddr3_mcb_rdat_vld is the same window delayed RD_PIPE.
- Write: d_dp_oe high T+cfg_cwl .. T+cfg_cwl+n-1; d_wr_ld is the oe window shifted earlier by 1; ddr3_mcb_wdat_req is the oe window shifted earlier by WREQ_LEAD.
- ddr3_mcb_wdat_req is the OR over all in-flight writes; overlapping requests never merge beats.

Implementation structure:
- Token shift register of depth 2^LAT_W, entry {vld, is_wr, bc4}; token enters at stage 0 on the command cycle.
- Per-direction burst launch is taken from the tap selected by cfg_cl/cfg_cwl (plus the lead taps for wr_ld/wdat_req).
- Per-direction burst counter, width log2(BL_CYC), counts 0..n-1 then idles.

Configuration:
- cfg_cl clamps to min 2. cfg_cwl clamps to min WREQ_LEAD+1.
- cfg_cl/cfg_cwl are sampled continuously; changing them while d_busy=1 gives undefined timing, but no hang and no X.

Seamless and collision rules:
- A burst launching on the cycle after the previous same-direction burst's last beat is legal and continuous.
- A burst launching while the same-direction counter has beats remaining: the counter restarts at 0 for the new burst (old burst truncated), and d_err is set the same cycle.
- c_rd and c_wr in the same cycle: the write is dropped, the read proceeds, and d_err is set the next cycle.
- d_dp_ie and d_dp_oe high in the same cycle: both are driven as scheduled, and d_err is set the next cycle.

d_err:
- Sticky until err_clr or reset.
- err_clr with a simultaneous new error leaves d_err = 1.

d_busy:
- High from the cycle after any command until the final rdat_vld/oe beat has completed.

Test Plan:
- cfg_cl=6, cfg_cwl=5 (defaults otherwise); c_wr BL8 at cycle 10 -> wdat_req 13..16, wr_ld 14..17, oe 15..18, d_beat 0..3; d_err=0.
- c_rd BL8 at 10 -> ie 16..19, rdat_vld 17..20; c_rd BC4 at 30 -> ie 36..37 only, d_beat 0,1.
- c_rd at 10 and 14 -> ie continuous 16..23, d_beat 0..3,0..3, d_err=0; c_rd at 10 and 12 -> ie 16..21, d_beat 0,1,0,1,2,3, d_err=1 from cycle 18.
- c_rd and c_wr both at 10 -> no oe/wdat_req pulses, ie 16..19, d_err=1 at 11; err_clr at 20 -> d_err=0 at 21.
- cfg_cl=5, cfg_cwl=5; c_rd at 10, c_wr at 10+BL_CYC/2=12 -> ie/oe overlap at 17..18, d_err=1 at 18.
- c_rd BL8 at 10; rst_n low at 17 for 2 cycles -> ie, rdat_vld and d_busy drop at 17 asynchronously and stay 0 after release.

Source files
------------

// File: rtl/ddr3_mcb_dat_sched.sv
// DDR3 MCB data-path scheduler: turns read/write command strobes into
// burst-aligned data-path enables using a token pipeline and runtime CL/CWL.
// Ports:
//   ddr3_mcb_clk/ddr3_mcb_rst_n : clock, async active-low reset
//   c_rd/c_wr/c_bc4             : command strobes, burst-chop qualifier
//   cfg_cl/cfg_cwl              : read/write latency (clamped to minimums)
//   err_clr                     : clears sticky d_err
//   d_dp_ie/d_dp_oe/d_wr_ld     : read capture, write drive, write load enables
//   ddr3_mcb_wdat_req           : user write-beat request
//   ddr3_mcb_rdat_vld           : user read-data valid
//   d_beat/d_busy/d_err         : beat index, activity, collision flag
module ddr3_mcb_dat_sched #(
    parameter int LAT_W     = 5,
    parameter int BL_CYC    = 4,
    parameter int WREQ_LEAD = 2,
    parameter int RD_PIPE   = 1
) (
    input  logic                      ddr3_mcb_clk,
    input  logic                      ddr3_mcb_rst_n,
    input  logic                      c_rd,
    input  logic                      c_wr,
    input  logic                      c_bc4,
    input  logic [LAT_W-1:0]          cfg_cl,
    input  logic [LAT_W-1:0]          cfg_cwl,
    input  logic                      err_clr,
    output logic                      d_dp_ie,
    output logic                      d_dp_oe,
    output logic                      d_wr_ld,
    output logic                      ddr3_mcb_wdat_req,
    output logic                      ddr3_mcb_rdat_vld,
    output logic [$clog2(BL_CYC)-1:0] d_beat,
    output logic                      d_busy,
    output logic                      d_err
);

    localparam int BW      = $clog2(BL_CYC);
    localparam int DEPTH   = 2 ** LAT_W;
    localparam int CWL_MIN = (WREQ_LEAD + 1 < 2) ? 2 : WREQ_LEAD + 1;
    localparam int NCH     = 4;
    localparam int CH_IE   = 0;
    localparam int CH_OE   = 1;
    localparam int CH_LD   = 2;
    localparam int CH_RQ   = 3;

    typedef struct packed {
        logic vld;
        logic is_wr;
        logic bc4;
    } tok_t;

    tok_t             tok_in;
    tok_t             tok_q   [1:DEPTH-1];
    tok_t             tok_all [DEPTH];
    tok_t             tap     [NCH];
    logic [LAT_W-1:0] tap_idx [NCH];
    logic [LAT_W-1:0] cl_eff;
    logic [LAT_W-1:0] cwl_eff;
    logic             pend;

    logic [NCH-1:0]   launch;
    logic [NCH-1:0]   coll;
    logic [NCH-1:0]   act_q,  act_d;
    logic [BW-1:0]    cnt_q   [NCH];
    logic [BW-1:0]    cnt_d   [NCH];
    logic [BW-1:0]    last_q  [NCH];
    logic [BW-1:0]    last_d  [NCH];

    logic [RD_PIPE-1:0] rv_q, rv_d;
    logic               err_q, err_d;

    // Tap k of tok_all holds the command issued k cycles ago; a tap of
    // latency-1 launches a burst whose first beat appears latency cycles later
    // because the channel state is registered.
    always_comb begin
        tok_in.vld   = c_rd | c_wr;
        tok_in.is_wr = c_wr & ~c_rd;
        tok_in.bc4   = c_bc4;

        cl_eff  = (cfg_cl < LAT_W'(2)) ? LAT_W'(2) : cfg_cl;
        cwl_eff = (cfg_cwl < LAT_W'(CWL_MIN)) ? LAT_W'(CWL_MIN) : cfg_cwl;

        tap_idx[CH_IE] = cl_eff - LAT_W'(1);
        tap_idx[CH_OE] = cwl_eff - LAT_W'(1);
        tap_idx[CH_LD] = cwl_eff - LAT_W'(2);
        tap_idx[CH_RQ] = cwl_eff - LAT_W'(WREQ_LEAD + 1);

        tok_all[0] = tok_in;
        for (int k = 1; k < DEPTH; k++) begin
            tok_all[k] = tok_q[k];
        end

        for (int c = 0; c < NCH; c++) begin
            tap[c] = tok_all[tap_idx[c]];
        end
    end

    // Tokens still waiting for their data launch keep the block busy;
    // those beyond their launch tap are spent.
    always_comb begin
        pend = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            if (tok_q[k].vld &&
                LAT_W'(k) <= (tok_q[k].is_wr ? tap_idx[CH_OE]
                                             : tap_idx[CH_IE])) begin
                pend = 1'b1;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            launch[c] = tap[c].vld &
                        ((c == CH_IE) ? ~tap[c].is_wr : tap[c].is_wr);
            act_d[c]  = act_q[c];
            cnt_d[c]  = cnt_q[c];
            last_d[c] = last_q[c];
            coll[c]   = 1'b0;
            if (launch[c]) begin
                // Launching on the last beat is seamless; earlier truncates.
                coll[c]   = act_q[c] && (cnt_q[c] != last_q[c]);
                act_d[c]  = 1'b1;
                cnt_d[c]  = '0;
                last_d[c] = tap[c].bc4 ? BW'(BL_CYC / 2 - 1)
                                       : BW'(BL_CYC - 1);
            end else if (act_q[c]) begin
                if (cnt_q[c] == last_q[c]) begin
                    act_d[c] = 1'b0;
                end else begin
                    cnt_d[c] = cnt_q[c] + BW'(1);
                end
            end
        end
    end

    always_comb begin
        rv_d    = '0;
        rv_d[0] = act_q[CH_IE];
        for (int i = 1; i < RD_PIPE; i++) begin
            rv_d[i] = rv_q[i-1];
        end

        if ((c_rd & c_wr) | (act_q[CH_IE] & act_q[CH_OE]) |
            coll[CH_IE] | coll[CH_OE]) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge ddr3_mcb_clk or negedge ddr3_mcb_rst_n) begin
        if (!ddr3_mcb_rst_n) begin
            for (int k = 1; k < DEPTH; k++) begin
                tok_q[k] <= '0;
            end
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c]  <= '0;
                last_q[c] <= '0;
            end
            act_q <= '0;
            rv_q  <= '0;
            err_q <= 1'b0;
        end else begin
            tok_q[1] <= tok_in;
            for (int k = 2; k < DEPTH; k++) begin
                tok_q[k] <= tok_q[k-1];
            end
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c]  <= cnt_d[c];
                last_q[c] <= last_d[c];
            end
            act_q <= act_d;
            rv_q  <= rv_d;
            err_q <= err_d;
        end
    end

    assign d_dp_ie           = act_q[CH_IE];
    assign d_dp_oe           = act_q[CH_OE];
    assign d_wr_ld           = act_q[CH_LD];
    assign ddr3_mcb_wdat_req = act_q[CH_RQ];
    assign ddr3_mcb_rdat_vld = rv_q[RD_PIPE-1];
    assign d_beat            = act_q[CH_IE] ? cnt_q[CH_IE] :
                               act_q[CH_OE] ? cnt_q[CH_OE] : '0;
    assign d_busy            = pend | (|act_q) | (|rv_q);
    assign d_err             = err_q;

endmodule

// File: tb/tb_ddr3_mcb_dat_sched.sv
// Scoreboard bench for ddr3_mcb_dat_sched: per-cycle expected output
// vectors are queued with each scenario's stimulus and popped each cycle.
module tb_ddr3_mcb_dat_sched;

    localparam int LAT_W     = 5;
    localparam int BL_CYC    = 4;
    localparam int WREQ_LEAD = 2;
    localparam int RD_PIPE   = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             c_rd, c_wr, c_bc4, err_clr;
    logic [LAT_W-1:0] cfg_cl, cfg_cwl;
    logic             d_dp_ie, d_dp_oe, d_wr_ld;
    logic             wdat_req, rdat_vld;
    logic [1:0]       d_beat;
    logic             d_busy, d_err;

    int checks   = 0;
    int failures = 0;
    logic [8:0] sb[$];

    ddr3_mcb_dat_sched #(
        .LAT_W(LAT_W), .BL_CYC(BL_CYC),
        .WREQ_LEAD(WREQ_LEAD), .RD_PIPE(RD_PIPE)
    ) dut (
        .ddr3_mcb_clk      (clk),
        .ddr3_mcb_rst_n    (rst_n),
        .c_rd              (c_rd),
        .c_wr              (c_wr),
        .c_bc4             (c_bc4),
        .cfg_cl            (cfg_cl),
        .cfg_cwl           (cfg_cwl),
        .err_clr           (err_clr),
        .d_dp_ie           (d_dp_ie),
        .d_dp_oe           (d_dp_oe),
        .d_wr_ld           (d_wr_ld),
        .ddr3_mcb_wdat_req (wdat_req),
        .ddr3_mcb_rdat_vld (rdat_vld),
        .d_beat            (d_beat),
        .d_busy            (d_busy),
        .d_err             (d_err)
    );

    always #5 clk = ~clk;

    function automatic logic w(int k, int s, int n);
        return (k >= s) && (k < s + n);
    endfunction

    function automatic logic [8:0] mk(logic ie, logic oe, logic ld,
                                      logic rq, logic rv, logic bs,
                                      logic er, logic [1:0] bt);
        return {ie, oe, ld, rq, rv, bs, er, bt};
    endfunction

    function automatic logic [8:0] obs();
        return mk(d_dp_ie, d_dp_oe, d_wr_ld, wdat_req, rdat_vld,
                  d_busy, d_err, d_beat);
    endfunction

    task automatic do_reset(input logic [LAT_W-1:0] cl,
                            input logic [LAT_W-1:0] cwl);
        c_rd = 0; c_wr = 0; c_bc4 = 0; err_clr = 0;
        cfg_cl = cl; cfg_cwl = cwl;
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
    endtask

    // vector order: ie oe ld req rv busy err beat[1:0]
    task automatic test_reset();
        logic [8:0] e;
        do_reset(6, 5);
        for (int k = 0; k < 4; k++) sb.push_back('0);
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL reset r=%0d got=%b exp=%b", r, obs(), e);
            end
        end
    endtask

    task automatic test_wr_bl8();
        logic [8:0] e;
        do_reset(6, 5);
        for (int k = 0; k < 25; k++)
            sb.push_back(mk(0, w(k, 15, 4), w(k, 14, 4), w(k, 13, 4), 0,
                            w(k, 11, 8), 0,
                            w(k, 15, 4) ? 2'(k - 15) : 2'd0));
        for (int r = 0; r < 25; r++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL wr_bl8 r=%0d got=%b exp=%b", r, obs(), e);
            end
            c_wr = (r == 10);
        end
    endtask

    task automatic test_rd_bl8_bc4();
        logic [8:0] e;
        do_reset(6, 5);
        for (int k = 0; k < 45; k++)
            sb.push_back(mk(w(k, 16, 4) | w(k, 36, 2), 0, 0, 0,
                            w(k, 17, 4) | w(k, 37, 2),
                            w(k, 11, 10) | w(k, 31, 8), 0,
                            w(k, 16, 4) ? 2'(k - 16) :
                            w(k, 36, 2) ? 2'(k - 36) : 2'd0));
        for (int r = 0; r < 45; r++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL rd_bl8_bc4 r=%0d got=%b exp=%b",
                         r, obs(), e);
            end
            c_rd  = (r == 10) || (r == 30);
            c_bc4 = (r == 30);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] e;
        do_reset(6, 5);
        for (int k = 0; k < 31; k++)
            sb.push_back(mk(w(k, 16, 8), 0, 0, 0, w(k, 17, 8),
                            w(k, 11, 14), 0,
                            w(k, 16, 8) ? 2'(k - 16) : 2'd0));
        for (int r = 0; r < 31; r++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL back_to_back r=%0d got=%b exp=%b",
                         r, obs(), e);
            end
            c_rd = (r == 10) || (r == 14);
        end
    endtask

    task automatic test_truncate();
        logic [8:0] e;
        do_reset(6, 5);
        for (int k = 0; k < 29; k++)
            sb.push_back(mk(w(k, 16, 6), 0, 0, 0, w(k, 17, 6),
                            w(k, 11, 12), k >= 18,
                            w(k, 16, 2) ? 2'(k - 16) :
                            w(k, 18, 4) ? 2'(k - 18) : 2'd0));
        for (int r = 0; r < 29; r++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL truncate r=%0d got=%b exp=%b", r, obs(), e);
            end
            c_rd = (r == 10) || (r == 12);
        end
    endtask

    task automatic test_rd_wr_same();
        logic [8:0] e;
        do_reset(6, 5);
        for (int k = 0; k < 27; k++)
            sb.push_back(mk(w(k, 16, 4), 0, 0, 0, w(k, 17, 4),
                            w(k, 11, 10), w(k, 11, 10),
                            w(k, 16, 4) ? 2'(k - 16) : 2'd0));
        for (int r = 0; r < 27; r++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL rd_wr_same r=%0d got=%b exp=%b",
                         r, obs(), e);
            end
            c_rd    = (r == 10);
            c_wr    = (r == 10);
            err_clr = (r == 20);
        end
    endtask

    task automatic test_ie_oe_overlap();
        logic [8:0] e;
        do_reset(5, 5);
        for (int k = 0; k < 27; k++)
            sb.push_back(mk(w(k, 15, 4), w(k, 17, 4), w(k, 16, 4),
                            w(k, 15, 4), w(k, 16, 4), w(k, 11, 10),
                            k >= 18,
                            w(k, 15, 4) ? 2'(k - 15) :
                            w(k, 19, 2) ? 2'(k - 17) : 2'd0));
        for (int r = 0; r < 27; r++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL ie_oe_overlap r=%0d got=%b exp=%b",
                         r, obs(), e);
            end
            c_rd = (r == 10);
            c_wr = (r == 12);
        end
    endtask

    task automatic test_clamp();
        logic [8:0] e;
        do_reset(1, 0);
        for (int k = 0; k < 32; k++)
            sb.push_back(mk(w(k, 12, 4), w(k, 23, 4), w(k, 22, 4),
                            w(k, 21, 4), w(k, 13, 4),
                            w(k, 11, 6) | w(k, 21, 6), 0,
                            w(k, 12, 4) ? 2'(k - 12) :
                            w(k, 23, 4) ? 2'(k - 23) : 2'd0));
        for (int r = 0; r < 32; r++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL clamp r=%0d got=%b exp=%b", r, obs(), e);
            end
            c_rd = (r == 10);
            c_wr = (r == 20);
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] e;
        do_reset(6, 5);
        for (int k = 0; k < 31; k++)
            sb.push_back(k > 17 ? 9'd0 :
                         mk(w(k, 16, 4), 0, 0, 0, w(k, 17, 4),
                            w(k, 11, 10), 0,
                            w(k, 16, 4) ? 2'(k - 16) : 2'd0));
        for (int r = 0; r < 31; r++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL reset_mid r=%0d got=%b exp=%b",
                         r, obs(), e);
            end
            c_rd = (r == 10);
            if (r == 17) begin
                rst_n = 0;
                #1;
                checks++;
                if ({d_dp_ie, rdat_vld, d_busy} !== 3'b000) begin
                    failures++;
                    $display("FAIL reset_async got=%b exp=000",
                             {d_dp_ie, rdat_vld, d_busy});
                end
            end
            if (r == 19) rst_n = 1;
        end
    endtask

    initial begin
        rst_n = 0;
        test_reset();
        test_wr_bl8();
        test_rd_bl8_bc4();
        test_back_to_back();
        test_truncate();
        test_rd_wr_same();
        test_ie_oe_overlap();
        test_clamp();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
